// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types for the register-file write-port controller.
//   tag_t        : ROB tag carried in the register-file tag slots
//   reg_id_t     : architectural register index
//   port_state_e : controller state (IDLE arbitrating, WALK clearing tags)
//   clr_port_t   : tag-clear port pair driven into the register file
package regfile_port_ctrl_pkg;

  localparam int TAG_W    = 5;
  localparam int REG_ID_W = 5;
  localparam int DATA_W   = 32;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [REG_ID_W-1:0] reg_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } port_state_e;

  typedef struct packed {
    logic    clr_tag;
    reg_id_t clr_id;
  } clr_port_t;

endpackage

// File: rtl/regfile_port_ctrl.sv
// Write-port controller in front of the out-of-order register file.
// Arbitrates the single per-cycle update slot between ROB commit (value
// write) and decoder tag allocation, with anti-starvation for the decoder.
// A flush starts a walk that clears the tags of x1..x(NUM_REGS-1), one per
// cycle, while both requesters are stalled.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 pipeline flush pulse (restarts the clear walk)
//   rob_*_i / rob_ready_o commit request and acceptance
//   dec_*_i / dec_ready_o tag-allocation request and acceptance
//   load_reg, reg_id_rob, reg_val, tag_rob   commit write to the regfile
//   load_tag, reg_id_decoder, tag_decoder    rename tag write to the regfile
//   clr_tag_o, clr_id_o   forced tag clear of one register
//   flush_busy_o          walk in progress
//   flush_done_o          one-cycle pulse in the first IDLE cycle after a walk
module regfile_port_ctrl
  import regfile_port_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_REGS     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              rob_valid_i,
  input  logic [4:0]        rob_rd_i,
  input  logic [31:0]       rob_val_i,
  input  tag_t              rob_tag_i,
  output logic              rob_ready_o,
  input  logic              dec_valid_i,
  input  logic [4:0]        dec_rd_i,
  input  tag_t              dec_tag_i,
  output logic              dec_ready_o,
  output logic              load_reg,
  output logic [4:0]        reg_id_rob,
  output logic [31:0]       reg_val,
  output tag_t              tag_rob,
  output logic              load_tag,
  output logic [4:0]        reg_id_decoder,
  output tag_t              tag_decoder,
  output logic              clr_tag_o,
  output logic [4:0]        clr_id_o,
  output logic              flush_busy_o,
  output logic              flush_done_o
);

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam reg_id_t           LAST_ID = reg_id_t'(NUM_REGS - 1);

  port_state_e      state_reg, state_next;
  reg_id_t          clr_id_reg, clr_id_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             done_reg, done_next;

  // A request targeting x0 is a no-op: it is acknowledged but never needs
  // the update slot, so only "real" requests compete.
  logic rob_real, dec_real, starved, accept_window;
  logic rob_grant, dec_grant;
  clr_port_t clr;

  assign rob_real      = rob_valid_i && (rob_rd_i != '0);
  assign dec_real      = dec_valid_i && (dec_rd_i != '0);
  assign starved       = (starve_cnt_reg == CNT_MAX);
  assign accept_window = !rst && !flush && (state_reg == IDLE);

  // Commit normally wins a real-vs-real conflict; a starved decoder flips it.
  assign rob_grant = accept_window && rob_valid_i && !(rob_real && dec_real && starved);
  assign dec_grant = accept_window && dec_valid_i && !(rob_real && dec_real && !starved);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      clr_id_reg     <= '0;
      starve_cnt_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_id_reg     <= clr_id_next;
      starve_cnt_reg <= starve_cnt_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    clr_id_next     = clr_id_reg;
    starve_cnt_next = starve_cnt_reg;
    done_next       = 1'b0;
    if (flush) begin
      // Flush in any state (re)starts the walk at x1; x0 is never cleared.
      state_next      = WALK;
      clr_id_next     = reg_id_t'(1);
      starve_cnt_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (dec_real && !dec_grant)
            starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 1'b1;
          else
            starve_cnt_next = '0;
        end
        WALK: begin
          if (clr_id_reg == LAST_ID) begin
            state_next  = IDLE;
            clr_id_next = '0;
            done_next   = 1'b1;
          end else begin
            clr_id_next = clr_id_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic; everything is held at zero while rst is asserted.
  always_comb begin
    rob_ready_o    = 1'b0;
    dec_ready_o    = 1'b0;
    load_reg       = 1'b0;
    reg_id_rob     = '0;
    reg_val        = '0;
    tag_rob        = '0;
    load_tag       = 1'b0;
    reg_id_decoder = '0;
    tag_decoder    = '0;
    clr            = '0;
    flush_busy_o   = 1'b0;
    flush_done_o   = 1'b0;
    if (!rst) begin
      rob_ready_o  = rob_grant;
      dec_ready_o  = dec_grant;
      flush_done_o = done_reg;
      if (state_reg == WALK) begin
        flush_busy_o = 1'b1;
        clr.clr_tag  = 1'b1;
        clr.clr_id   = clr_id_reg;
      end
      if (rob_grant && rob_real) begin
        load_reg   = 1'b1;
        reg_id_rob = rob_rd_i;
        reg_val    = rob_val_i;
        tag_rob    = rob_tag_i;
      end
      if (dec_grant && dec_real) begin
        load_tag       = 1'b1;
        reg_id_decoder = dec_rd_i;
        tag_decoder    = dec_tag_i;
      end
    end
  end

  assign clr_tag_o = clr.clr_tag;
  assign clr_id_o  = clr.clr_id;

endmodule
